// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transaction engine: FSM states,
// command/address bit positions and the latched request record.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CA,
        S_LATENCY,
        S_WRITE,
        S_READ,
        S_CS_HOLD,
        S_DONE
    } state_t;

    localparam int         CA_CYCLES   = 3;
    localparam logic [1:0] CA_LAST     = 2'(CA_CYCLES - 1);

    localparam int CA_RW_BIT   = 47;
    localparam int CA_AS_BIT   = 46;
    localparam int CA_BT_BIT   = 45;
    localparam int CA_ADDR_HI  = 44;
    localparam int CA_ADDR_LO  = 16;
    localparam int CA_LADDR_HI = 2;

    // Burst and CS fields are sized for the widest supported configuration.
    localparam int REQ_BURST_W = 32;
    localparam int REQ_CS_W    = 8;

    typedef struct packed {
        logic [31:0]            addr;
        logic                   write;
        logic                   reg_space;
        logic [REQ_BURST_W-1:0] burst;
        logic [REQ_CS_W-1:0]    cs;
    } req_t;

endpackage

// File: rtl/hyperbus_ca_gen.sv
// Builds the 48-bit command/address word and selects the half-word for the
// current CA cycle; purely combinational, no backpressure.
module hyperbus_ca_gen
    import hyperbus_pkg::*;
(
    input  logic [31:0] addr,
    input  logic        write,
    input  logic        reg_space,
    input  logic [1:0]  ca_idx,
    output logic [15:0] ca_half
);

    logic [47:0] ca_word;

    always_comb begin
        ca_word                         = '0;
        ca_word[CA_RW_BIT]              = ~write;
        ca_word[CA_AS_BIT]              = reg_space;
        ca_word[CA_BT_BIT]              = 1'b1;
        ca_word[CA_ADDR_HI:CA_ADDR_LO]  = addr[31:3];
        ca_word[CA_LADDR_HI:0]          = addr[2:0];
        case (ca_idx)
            2'd0:    ca_half = ca_word[47:32];
            2'd1:    ca_half = ca_word[31:16];
            default: ca_half = ca_word[15:0];
        endcase
    end

endmodule

// File: rtl/hyperbus_txn_fsm.sv
// One HyperBus transaction per request: CS setup, 3-cycle CA, latency, burst, CS hold, done pulse.
// Write words stall on tx_valid_i=0 (clock gated); read words have no backpressure and time out.
module hyperbus_txn_fsm
    import hyperbus_pkg::*;
#(
    parameter int  NR_CS      = 2,
    parameter int  BURST_W    = 16,
    parameter int  RD_TIMEOUT = 64,
    parameter int  MAX_CSH    = 15,
    localparam int CS_W       = (NR_CS > 1) ? $clog2(NR_CS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trans_valid_i,
    output logic               trans_ready_o,
    input  logic [31:0]        trans_addr_i,
    input  logic               trans_write_i,
    input  logic               trans_reg_i,
    input  logic [BURST_W-1:0] trans_burst_i,
    input  logic [CS_W-1:0]    trans_cs_i,
    input  logic [3:0]         cfg_latency_i,
    input  logic [3:0]         cfg_csh_i,
    input  logic [15:0]        tx_data_i,
    input  logic [1:0]         tx_strb_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [15:0]        rx_data_o,
    output logic               rx_valid_o,
    output logic               trans_done_o,
    output logic               trans_error_o,
    output logic [NR_CS-1:0]   phy_cs_no,
    output logic               phy_ck_en_o,
    output logic [15:0]        phy_dq_o,
    output logic               phy_dq_oe_o,
    output logic [1:0]         phy_rwds_o,
    output logic               phy_rwds_oe_o,
    input  logic               phy_rwds_i,
    input  logic [15:0]        phy_dq_i
);

    localparam int         TO_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);
    localparam logic [3:0] CSH_CAP  = 4'(MAX_CSH);

    state_t          state;
    req_t            req;
    logic [1:0]      ca_idx;
    logic            dbl;
    logic [4:0]      lat_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      hold_cnt;
    logic            err;
    logic [15:0]     rx_data_q;
    logic            rx_valid_q;

    logic [15:0]     ca_half;
    logic [4:0]      lat_total;
    logic [3:0]      csh_eff;
    state_t          after_burst;
    logic            wr_fire;
    logic            cs_active;

    hyperbus_ca_gen u_ca_gen (
        .addr      (req.addr),
        .write     (req.write),
        .reg_space (req.reg_space),
        .ca_idx    (ca_idx),
        .ca_half   (ca_half)
    );

    assign lat_total   = dbl ? {cfg_latency_i, 1'b0} : {1'b0, cfg_latency_i};
    assign csh_eff     = (cfg_csh_i > CSH_CAP) ? CSH_CAP : cfg_csh_i;
    assign after_burst = (csh_eff == 4'd0) ? S_DONE : S_CS_HOLD;
    assign wr_fire     = (state == S_WRITE) && tx_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            req        <= '0;
            ca_idx     <= '0;
            dbl        <= 1'b0;
            lat_cnt    <= '0;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            err        <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trans_valid_i) begin
                        req.addr      <= trans_addr_i;
                        req.write     <= trans_write_i;
                        req.reg_space <= trans_reg_i;
                        req.burst     <= (trans_burst_i == '0) ? REQ_BURST_W'(1)
                                                               : REQ_BURST_W'(trans_burst_i);
                        req.cs        <= REQ_CS_W'(trans_cs_i);
                        state         <= S_CS_SETUP;
                    end
                end
                S_CS_SETUP: begin
                    ca_idx <= '0;
                    to_cnt <= '0;
                    dbl    <= 1'b0;
                    state  <= S_CA;
                end
                S_CA: begin
                    if (ca_idx == 2'd0) dbl <= phy_rwds_i;
                    if (ca_idx == CA_LAST) begin
                        ca_idx <= '0;
                        // Register writes carry no latency at all, regardless of the flag.
                        if (req.write && req.reg_space)
                            state <= S_WRITE;
                        else if (lat_total == 5'd0)
                            state <= req.write ? S_WRITE : S_READ;
                        else begin
                            lat_cnt <= lat_total - 5'd1;
                            state   <= S_LATENCY;
                        end
                    end else begin
                        ca_idx <= ca_idx + 2'd1;
                    end
                end
                S_LATENCY: begin
                    if (lat_cnt == 5'd0)
                        state <= req.write ? S_WRITE : S_READ;
                    else
                        lat_cnt <= lat_cnt - 5'd1;
                end
                S_WRITE: begin
                    if (tx_valid_i) begin
                        if (req.burst == REQ_BURST_W'(1)) begin
                            hold_cnt <= csh_eff - 4'd1;
                            state    <= after_burst;
                        end else begin
                            req.burst <= req.burst - REQ_BURST_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (phy_rwds_i) begin
                        rx_data_q  <= phy_dq_i;
                        rx_valid_q <= 1'b1;
                        to_cnt     <= '0;
                        if (req.burst == REQ_BURST_W'(1)) begin
                            hold_cnt <= csh_eff - 4'd1;
                            state    <= after_burst;
                        end else begin
                            req.burst <= req.burst - REQ_BURST_W'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        err      <= 1'b1;
                        hold_cnt <= csh_eff - 4'd1;
                        state    <= after_burst;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_CS_HOLD: begin
                    if (hold_cnt == 4'd0)
                        state <= S_DONE;
                    else
                        hold_cnt <= hold_cnt - 4'd1;
                end
                S_DONE: begin
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cs_active = (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        phy_cs_no = '1;
        for (int i = 0; i < NR_CS; i++)
            phy_cs_no[i] = !(cs_active && (req.cs == REQ_CS_W'(i)));
    end

    // PHY outputs are decoded from the state register; only write data passes straight through.
    always_comb begin
        phy_ck_en_o   = (state == S_CA) || (state == S_LATENCY) || (state == S_READ) || wr_fire;
        phy_dq_oe_o   = (state == S_CA) || wr_fire;
        phy_dq_o      = (state == S_CA) ? ca_half : (wr_fire ? tx_data_i : 16'h0000);
        phy_rwds_oe_o = wr_fire && !req.reg_space;
        phy_rwds_o    = phy_rwds_oe_o ? ~tx_strb_i : 2'b00;
    end

    assign trans_ready_o = (state == S_IDLE) && !rst_i;
    assign tx_ready_o    = (state == S_WRITE);
    assign trans_done_o  = (state == S_DONE);
    assign trans_error_o = (state == S_DONE) && err;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_hyperbus_txn_fsm.sv
// Bench: builds each transaction's expected bus timeline from the protocol rules, then replays it.
module tb_hyperbus_txn_fsm;

    localparam int NR_CS = 3;
    localparam int CS_W  = 2;
    localparam int RD_TO = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i;
    logic        trans_write_i;
    logic        trans_reg_i;
    logic [15:0] trans_burst_i;
    logic [CS_W-1:0] trans_cs_i;
    logic [3:0]  cfg_latency_i;
    logic [3:0]  cfg_csh_i;
    logic [15:0] tx_data_i;
    logic [1:0]  tx_strb_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        trans_done_o;
    logic        trans_error_o;
    logic [NR_CS-1:0] phy_cs_no;
    logic        phy_ck_en_o;
    logic [15:0] phy_dq_o;
    logic        phy_dq_oe_o;
    logic [1:0]  phy_rwds_o;
    logic        phy_rwds_oe_o;
    logic        phy_rwds_i;
    logic [15:0] phy_dq_i;

    always #5 clk_i = ~clk_i;

    hyperbus_txn_fsm #(
        .NR_CS(NR_CS), .BURST_W(16), .RD_TIMEOUT(RD_TO), .MAX_CSH(15)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .trans_addr_i(trans_addr_i), .trans_write_i(trans_write_i),
        .trans_reg_i(trans_reg_i), .trans_burst_i(trans_burst_i),
        .trans_cs_i(trans_cs_i), .cfg_latency_i(cfg_latency_i), .cfg_csh_i(cfg_csh_i),
        .tx_data_i(tx_data_i), .tx_strb_i(tx_strb_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .trans_done_o(trans_done_o), .trans_error_o(trans_error_o),
        .phy_cs_no(phy_cs_no), .phy_ck_en_o(phy_ck_en_o), .phy_dq_o(phy_dq_o),
        .phy_dq_oe_o(phy_dq_oe_o), .phy_rwds_o(phy_rwds_o), .phy_rwds_oe_o(phy_rwds_oe_o),
        .phy_rwds_i(phy_rwds_i), .phy_dq_i(phy_dq_i)
    );

    // One bus cycle: stimulus to apply and outputs expected in that cycle.
    typedef struct packed {
        logic        tx_valid;
        logic [15:0] tx_data;
        logic [1:0]  tx_strb;
        logic        rwds_in;
        logic [15:0] dq_in;
        logic [2:0]  cs_n;
        logic        ck_en;
        logic        dq_oe;
        logic [15:0] dq;
        logic        rwds_oe;
        logic [1:0]  rwds;
        logic        tx_ready;
        logic        rx_valid;
        logic [15:0] rx_data;
        logic        done;
        logic        err;
        logic        tready;
    } cyc_t;

    cyc_t        tl[$];
    logic        pend;
    logic [15:0] pend_d;
    int          n_total = 0;
    int          n_bad   = 0;

    logic [31:0] q_addr;
    logic        q_w, q_r;
    logic [15:0] q_burst;
    logic [1:0]  q_cs;
    logic [3:0]  q_lat, q_csh;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [2:0] cs, input logic ck, input logic oe,
                                         input logic [15:0] dq, input logic roe, input logic [1:0] rw,
                                         input logic txr, input logic rxv, input logic [15:0] rxd,
                                         input logic dn, input logic er, input logic tr);
        return {19'd0, cs, ck, oe, dq, roe, rw, txr, rxv, rxd, dn, er, tr};
    endfunction

    function automatic logic [63:0] got_vec(input cyc_t e);
        return pack(phy_cs_no, phy_ck_en_o, phy_dq_oe_o, e.dq_oe ? phy_dq_o : 16'h0,
                    phy_rwds_oe_o, e.rwds_oe ? phy_rwds_o : 2'b00, tx_ready_o, rx_valid_o,
                    e.rx_valid ? rx_data_o : 16'h0, trans_done_o, trans_error_o, trans_ready_o);
    endfunction

    function automatic logic [63:0] exp_vec(input cyc_t e);
        return pack(e.cs_n, e.ck_en, e.dq_oe, e.dq, e.rwds_oe, e.rwds, e.tx_ready, e.rx_valid,
                    e.rx_data, e.done, e.err, e.tready);
    endfunction

    function automatic cyc_t base_c(input logic [2:0] sel);
        cyc_t c;
        c       = '0;
        c.cs_n  = sel;
        c.dq_in = 16'($urandom);
        return c;
    endfunction

    // A read word captured in one cycle shows up on rx the following cycle.
    task automatic push(input cyc_t c);
        cyc_t x;
        x = c;
        if (pend) begin
            x.rx_valid = 1'b1;
            x.rx_data  = pend_d;
            pend       = 1'b0;
        end
        tl.push_back(x);
    endtask

    // mode: 0 no gaps, 1 random gaps, 2 three-cycle stall before word 2, 3 read with no words.
    task automatic build(input logic [31:0] addr, input logic w, input logic r, input int burst,
                         input int cs, input int lat, input int csh, input logic dbl,
                         input int mode, input logic [63:0] dat, input int ndat);
        int n, e, gaps;
        logic [47:0] ca;
        logic [2:0]  sel;
        logic [15:0] d;
        cyc_t c;
        n   = (burst == 0) ? 1 : burst;
        sel = 3'b111;
        if (cs < NR_CS) sel[cs] = 1'b0;
        ca  = {~w, r, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        e   = (w && r) ? 0 : (dbl ? 2 * lat : lat);
        q_addr = addr; q_w = w; q_r = r; q_burst = 16'(burst);
        q_cs = 2'(cs); q_lat = 4'(lat); q_csh = 4'(csh);
        tl.delete();
        pend = 1'b0;
        push(base_c(sel));
        for (int i = 0; i < 3; i++) begin
            c = base_c(sel); c.ck_en = 1; c.dq_oe = 1; c.dq = ca[47-16*i -: 16];
            c.rwds_in = (i == 0) ? dbl : 1'($urandom);
            push(c);
        end
        for (int i = 0; i < e; i++) begin
            c = base_c(sel); c.ck_en = 1; push(c);
        end
        if (w) begin
            for (int j = 0; j < n; j++) begin
                gaps = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2 && j == 2) ? 3 : 0);
                for (int g = 0; g < gaps; g++) begin
                    c = base_c(sel); c.tx_ready = 1;
                    c.tx_data = 16'($urandom); c.tx_strb = 2'($urandom);
                    push(c);
                end
                d = (j < ndat) ? dat[63-16*j -: 16] : 16'($urandom);
                c = base_c(sel); c.tx_valid = 1; c.tx_data = d; c.tx_strb = 2'($urandom);
                c.tx_ready = 1; c.ck_en = 1; c.dq_oe = 1; c.dq = d;
                c.rwds_oe = !r; c.rwds = r ? 2'b00 : ~c.tx_strb;
                push(c);
            end
        end else if (mode == 3) begin
            for (int i = 0; i < RD_TO; i++) begin
                c = base_c(sel); c.ck_en = 1; push(c);
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                gaps = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
                for (int g = 0; g < gaps; g++) begin
                    c = base_c(sel); c.ck_en = 1; push(c);
                end
                d = (j < ndat) ? dat[63-16*j -: 16] : 16'($urandom);
                c = base_c(sel); c.ck_en = 1; c.rwds_in = 1; c.dq_in = d;
                push(c);
                pend = 1'b1; pend_d = d;
            end
        end
        for (int i = 0; i < csh; i++) push(base_c(sel));
        c = base_c(3'b111); c.done = 1; c.err = (!w && mode == 3); push(c);
        c = base_c(3'b111); c.tready = 1; push(c);
    endtask

    task automatic run(input int id, input int limit);
        int n;
        n = (limit < 0) ? tl.size() : limit;
        @(negedge clk_i);
        trans_valid_i = 1; trans_addr_i = q_addr; trans_write_i = q_w; trans_reg_i = q_r;
        trans_burst_i = q_burst; trans_cs_i = q_cs; cfg_latency_i = q_lat; cfg_csh_i = q_csh;
        tx_valid_i = 0; phy_rwds_i = 0;
        #1 check($sformatf("t%0d accept", id), 64'(trans_ready_o), 64'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            trans_valid_i = 0; trans_addr_i = $urandom; trans_write_i = 1'($urandom);
            trans_reg_i = 1'($urandom); trans_burst_i = 16'($urandom); trans_cs_i = 2'($urandom);
            tx_valid_i = tl[i].tx_valid; tx_data_i = tl[i].tx_data; tx_strb_i = tl[i].tx_strb;
            phy_rwds_i = tl[i].rwds_in; phy_dq_i = tl[i].dq_in;
            #1 check($sformatf("t%0d cyc%0d", id, i), got_vec(tl[i]), exp_vec(tl[i]));
        end
    endtask

    initial begin
        cyc_t z;
        int   id;
        rst_i = 1; trans_valid_i = 0; trans_addr_i = 0; trans_write_i = 0; trans_reg_i = 0;
        trans_burst_i = 0; trans_cs_i = 0; cfg_latency_i = 0; cfg_csh_i = 0;
        tx_data_i = 0; tx_strb_i = 0; tx_valid_i = 0; phy_rwds_i = 0; phy_dq_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        z = '0; z.cs_n = 3'b111;
        #1 check("reset state", got_vec(z), exp_vec(z));
        rst_i = 0;
        @(negedge clk_i);
        z.tready = 1;
        #1 check("idle after reset", got_vec(z), exp_vec(z));

        build(32'h0000_1000, 1, 0, 4, 0, 6, 2, 1'b0, 0, 64'd0, 0);           run(1, -1);
        build(32'h0002_0005, 0, 0, 2, 1, 6, 1, 1'b1, 0, {16'hBEEF, 16'hCAFE, 32'd0}, 2); run(2, -1);
        build(32'h0000_0800, 1, 1, 1, 0, 5, 3, 1'b1, 0, {16'h8F1F, 48'd0}, 1); run(3, -1);
        build(32'h0000_2000, 1, 0, 4, 2, 3, 0, 1'b0, 2, 64'd0, 0);           run(4, -1);
        build(32'h0000_3000, 0, 0, 1, 2, 4, 1, 1'b0, 3, 64'd0, 0);           run(5, -1);
        build(32'h0000_3008, 0, 0, 0, 3, 0, 2, 1'b0, 3, 64'd0, 0);           run(6, -1);
        build(32'hFFFF_FFFF, 1, 0, 0, 1, 0, 15, 1'b1, 0, 64'd0, 0);          run(7, -1);

        id = 10;
        repeat (14) begin
            build($urandom, 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4)), 1'($urandom), 1, 64'd0, 0);
            run(id, -1);
            id++;
        end

        // Reset while in the latency phase of a read.
        build(32'h0000_4000, 0, 0, 2, 1, 6, 2, 1'b0, 0, 64'd0, 0);
        run(99, 6);
        @(negedge clk_i);
        rst_i = 1; tx_valid_i = 0; phy_rwds_i = 0;
        @(negedge clk_i);
        #1 check("rst mid cs", 64'(phy_cs_no), 64'h7);
        check("rst mid done", 64'(trans_done_o), 64'd0);
        check("rst mid ready", 64'(trans_ready_o), 64'd0);
        rst_i = 0;
        @(negedge clk_i);
        #1 check("rst release ready", 64'(trans_ready_o), 64'd1);
        repeat (20) begin
            @(negedge clk_i);
            #1 check("post rst quiet", {62'd0, trans_done_o, rx_valid_o}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hyperbus_txn_fsm.md
Name: hyperbus_txn_fsm

Overview:
- Parametrised HyperBus transaction engine, one generation on from the stub hyperbus top.
- Accepts one transaction request (address, word count, read/write, register/memory space, chip select) and drives the command/address phase, initial latency (fixed or doubled), the data burst and CS hold.
- PHY side is 16 bits per clk_i cycle; the DDR split and clock generation live in the downstream PHY.
- Sits between the AXI/REG front end and the hyperbus PHY inside hyperbus.

Parameters:
- NR_CS, 2, number of chip selects (>=1)
- BURST_W, 16, width of word-count field
- RD_TIMEOUT, 64, max cycles waiting for a read word before abort
- MAX_CSH, 15, max CS hold cycles

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- trans_valid_i  in  1  request valid
- trans_ready_o  out  1  request accepted
- trans_addr_i  in  32  half-word address
- trans_write_i  in  1  1=write
- trans_reg_i  in  1  1=register space
- trans_burst_i  in  BURST_W  number of 16-bit words, 0 treated as 1
- trans_cs_i  in  $clog2(NR_CS) (min 1)  chip select index
- cfg_latency_i  in  4  initial latency cycles
- cfg_csh_i  in  4  CS hold cycles after last word
- tx_data_i  in  16  write data
- tx_strb_i  in  2  byte strobes, 1=write byte
- tx_valid_i  in  1  write word valid
- tx_ready_o  out  1  write word consumed
- rx_data_o  out  16  read data
- rx_valid_o  out  1  read word valid, 1-cycle pulse, no backpressure
- trans_done_o  out  1  1-cycle completion pulse
- trans_error_o  out  1  qualifies trans_done_o; read timeout
- phy_cs_no  out  NR_CS  active-low chip selects
- phy_ck_en_o  out  1  bus clock enable
- phy_dq_o  out  16  data out
- phy_dq_oe_o  out  1  dq drive enable
- phy_rwds_o  out  2  write mask (1=masked)
- phy_rwds_oe_o  out  1  rwds drive enable
- phy_rwds_i  in  1  latency flag in CA phase / read word valid in READ
- phy_dq_i  in  16  read data

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset: state IDLE. phy_cs_no all 1. All other outputs 0. trans_ready_o=0 during reset.
- States: IDLE, CS_SETUP, CA, LATENCY, WRITE, READ, CS_HOLD, DONE.
- IDLE:
  - trans_ready_o=1.
  - On valid&ready, latch all request fields (counter = burst, 0 -> 1), then go to CS_SETUP.
- CS_SETUP: 1 cycle. Selected phy_cs_no bit goes low; ck_en=0.
- CA: 3 cycles, ck_en=1, dq_oe=1. CA word 47:0 is driven MSB half-word first:
  - [47] = ~write
  - [46] = reg
  - [45] = 1 (linear burst)
  - [44:16] = addr[31:3]
  - [15:3] = 0
  - [2:0] = addr[2:0]
  - phy_rwds_i sampled in the first CA cycle; 1 means double latency.
- Latency decision after CA:
  - Register write: go straight to WRITE, zero latency.
  - Otherwise go to LATENCY for L = cfg_latency_i, or 2*L if doubled.
  - L=0 skips LATENCY.
  - Latency counter is 5 bits.
- LATENCY: ck_en=1, dq_oe=0. Leave when the count reaches 0: to WRITE or READ.
- WRITE:
  - tx_ready_o=1.
  - Each valid&ready cycle: dq_o=tx_data_i, dq_oe=1, rwds_oe=1, rwds_o=~tx_strb_i, ck_en=1, counter decrements.
  - tx_valid_i=0 stalls: ck_en=0, no count.
  - Last word goes to CS_HOLD.
  - Register write ignores strobes: rwds_oe=0.
- READ:
  - ck_en=1.
  - phy_rwds_i=1 captures phy_dq_i; rx_valid_o pulses the next cycle with the registered data; counter decrements.
  - Timeout counter resets on every word. At RD_TIMEOUT cycles without a word, set the error flag and go to CS_HOLD.
  - Last word goes to CS_HOLD.
- CS_HOLD: ck_en=0, CS still low for cfg_csh_i cycles (0 means none), then DONE.
- DONE:
  - All CS high.
  - trans_done_o=1 for exactly 1 cycle, trans_error_o=error flag.
  - Error flag clears, then IDLE.
  - trans_ready_o=0 outside IDLE, so back-to-back requests have at least 1 idle cycle.
- Reset mid-transaction: CS deasserts the next cycle. No done pulse. Partial data is dropped.
- trans_cs_i >= NR_CS: no CS asserted. Bus sequencing proceeds normally; a read on it times out.

Decomposition:
- Package hyperbus_pkg:
  - state enum
  - CA bit-position constants
  - CA_CYCLES=3
  - request struct (addr, write, reg, burst, cs)
- One natural sub-module, hyperbus_ca_gen: combinational CA word builder plus 3:1 half-word mux, indexed by CA cycle.

Test Plan:
- Memory write: addr=0x0000_1000, burst=4, latency=6, rwds_i=0 in CA -> CA half-words 0x2000,0x0200,0x0000; 6 latency cycles; 4 data words with rwds_o=~strb; done, error=0.
- Memory read: rwds_i=1 in CA, latency=6, burst=2 -> 12 latency cycles; rwds_i pulses with dq 0xBEEF,0xCAFE -> rx_valid_o twice, data in order; done, error=0.
- Register write: reg=1, burst=1, data 0x8F1F -> no LATENCY state; rwds_oe=0; done 1 cycle after cfg_csh_i hold.
- Write stall: tx_valid_i low 3 cycles mid-burst -> ck_en=0 for those 3 cycles, word count unchanged, burst completes.
- Read timeout: no rwds_i for 64 cycles, burst=1 -> done with error=1, CS high afterwards.
- Reset in LATENCY -> phy_cs_no=all 1 next cycle, no done pulse, trans_ready_o=1 after reset release.
